// File: rtl/id_operand_stage.sv
// ID/EX operand stage: resolves both source operands from the regfile, the immediate or the
// forwarding channels. It flags load-use hazards, resolves MOVN/MOVZ and registers toward EX.
module id_operand_stage #(
    parameter int unsigned DW      = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid_i,
    input  logic                   reg1_read_i,
    input  logic                   reg2_read_i,
    input  logic [4:0]             reg1_addr_i,
    input  logic [4:0]             reg2_addr_i,
    input  logic [DW-1:0]          imm_i,
    input  logic [7:0]             aluop_i,
    input  logic [2:0]             alusel_i,
    input  logic [4:0]             wd_i,
    input  logic                   wreg_i,
    input  logic [1:0]             cond_mode_i,
    input  logic [DW-1:0]          reg1_data_i,
    input  logic [DW-1:0]          reg2_data_i,
    input  logic [NUM_FWD-1:0]     fwd_wreg_i,
    input  logic [5*NUM_FWD-1:0]   fwd_wd_i,
    input  logic [DW*NUM_FWD-1:0]  fwd_wdata_i,
    input  logic [NUM_FWD-1:0]     fwd_pending_i,
    input  logic                   flush_i,
    input  logic                   ex_stall_i,
    output logic                   stallreq_o,
    output logic                   ex_valid_o,
    output logic [7:0]             ex_aluop_o,
    output logic [2:0]             ex_alusel_o,
    output logic [DW-1:0]          ex_reg1_o,
    output logic [DW-1:0]          ex_reg2_o,
    output logic [4:0]             ex_wd_o,
    output logic                   ex_wreg_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);

    localparam int unsigned AW = 5;

    localparam logic [1:0] COND_MOVN = 2'b01;
    localparam logic [1:0] COND_MOVZ = 2'b10;

    typedef struct packed {
        logic          valid;
        logic [7:0]    aluop;
        logic [2:0]    alusel;
        logic [DW-1:0] reg1;
        logic [DW-1:0] reg2;
        logic [AW-1:0] wd;
        logic          wreg;
    } ex_t;

    ex_t             ex_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [DW:0]     res1, res2;
    logic [DW-1:0]   op1, op2;
    logic            hz1, hz2, hazard;
    logic            eff_wreg;

    // Youngest matching channel wins; result is {hazard, data}
    function automatic logic [DW:0] resolve(
        input logic                  rd,
        input logic [AW-1:0]         addr,
        input logic [DW-1:0]         rf_data,
        input logic [DW-1:0]         imm,
        input logic [NUM_FWD-1:0]    wreg,
        input logic [AW*NUM_FWD-1:0] wd,
        input logic [DW*NUM_FWD-1:0] wdata,
        input logic [NUM_FWD-1:0]    pend
    );
        logic          found;
        logic          hz;
        logic [DW-1:0] d;
        found = 1'b0;
        hz    = 1'b0;
        d     = rf_data;
        if (!rd) begin
            d = imm;
        end else if (addr == '0) begin
            d = '0;
        end else begin
            for (int i = 0; i < NUM_FWD; i++) begin
                if (!found && wreg[i] && (wd[AW*i +: AW] == addr)) begin
                    found = 1'b1;
                    hz    = pend[i];
                    d     = wdata[DW*i +: DW];
                end
            end
        end
        return {hz, d};
    endfunction

    always_comb begin
        res1 = resolve(reg1_read_i, reg1_addr_i, reg1_data_i, imm_i,
                       fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pending_i);
        res2 = resolve(reg2_read_i, reg2_addr_i, reg2_data_i, imm_i,
                       fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pending_i);
        hz1    = res1[DW];
        hz2    = res2[DW];
        op1    = res1[DW-1:0];
        op2    = res2[DW-1:0];
        hazard = id_valid_i & (hz1 | hz2);
    end

    // Conditional moves test the forwarded op2, not the raw regfile value
    always_comb begin
        eff_wreg = wreg_i;
        if (cond_mode_i == COND_MOVN) begin
            eff_wreg = wreg_i & (op2 != '0);
        end else if (cond_mode_i == COND_MOVZ) begin
            eff_wreg = wreg_i & (op2 == '0);
        end
    end

    always_comb begin
        ex_d        = ex_q;
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            ex_d = '0;
        end else if (ex_stall_i) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d = '0;
        end else if (id_valid_i) begin
            ex_d.valid  = 1'b1;
            ex_d.aluop  = aluop_i;
            ex_d.alusel = alusel_i;
            ex_d.reg1   = op1;
            ex_d.reg2   = op2;
            ex_d.wd     = wd_i;
            ex_d.wreg   = eff_wreg;
        end else begin
            ex_d = '0;
        end
        if (hazard && !flush_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallreq_o  = hazard;
    assign ex_valid_o  = ex_q.valid;
    assign ex_aluop_o  = ex_q.aluop;
    assign ex_alusel_o = ex_q.alusel;
    assign ex_reg1_o   = ex_q.reg1;
    assign ex_reg2_o   = ex_q.reg2;
    assign ex_wd_o     = ex_q.wd;
    assign ex_wreg_o   = ex_q.wreg;
    assign stall_cnt_o = stall_cnt_q;

endmodule
